// File: rtl/log_msg_if.sv
// log_msg_if: log byte-stream input, replayed payload output and per-message metadata
interface log_msg_if #(parameter int TS_WIDTH = 32);
   logic                s_axis_valid;
   logic                s_axis_ready;
   logic [7:0]          s_axis_data;
   logic                s_axis_last;
   logic                m_axis_valid;
   logic                m_axis_ready;
   logic [7:0]          m_axis_data;
   logic                m_axis_last;
   logic [1:0]          m_sev;
   logic [1:0]          m_verb;
   logic                m_trunc;
   logic                m_empty;
   logic [TS_WIDTH-1:0] m_timestamp;
   modport slave (
      input  s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
      output s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
             m_sev, m_verb, m_trunc, m_empty, m_timestamp
   );
   modport master (
      output s_axis_valid, s_axis_data, s_axis_last, m_axis_ready,
      input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_last,
             m_sev, m_verb, m_trunc, m_empty, m_timestamp
   );
endinterface

// File: rtl/log_msg_receiver.sv
// log_msg_receiver: parses, filters, timestamps, buffers and replays log messages,
// keeping saturating per-severity counters and a sticky fatal flag
module log_msg_receiver #(
   parameter int MAX_LEN   = 128,
   parameter int TS_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cfg_verbosity,
   log_msg_if.slave             bus,
   output logic [CNT_WIDTH-1:0] cnt_info,
   output logic [CNT_WIDTH-1:0] cnt_warning,
   output logic [CNT_WIDTH-1:0] cnt_error,
   output logic [CNT_WIDTH-1:0] cnt_dropped,
   output logic                 fatal_seen
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;
   localparam logic [1:0] EMIT    = 2'd3;

   logic [1:0]          state;
   logic [LW-1:0]       len, nextLen, rdPtr, emitLen;
   logic [7:0]          mem [MAX_LEN];
   logic [TS_WIDTH-1:0] tsCount;
   logic                sHs, mHs, hdrOk, lenFull, commitFwd, commitDrop;
   logic [1:0]          fwdSev;

   function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] c, input logic en);
      return (en && !(&c)) ? c + CNT_WIDTH'(1) : c;
   endfunction

   always_comb begin
      bus.s_axis_ready = state != EMIT;
      sHs        = bus.s_axis_valid && bus.s_axis_ready;
      mHs        = bus.m_axis_valid && bus.m_axis_ready;
      hdrOk      = bus.s_axis_data[7:4] == 4'hA &&
                   !(bus.s_axis_data[3:2] == 2'd0 && bus.s_axis_data[1:0] > cfg_verbosity);
      lenFull    = len == LW'(MAX_LEN);
      nextLen    = lenFull ? len : len + LW'(1);
      fwdSev     = state == IDLE ? bus.s_axis_data[3:2] : bus.m_sev;
      commitFwd  = sHs && bus.s_axis_last && ((state == IDLE && hdrOk) || state == PAYLOAD);
      commitDrop = sHs && bus.s_axis_last && ((state == IDLE && !hdrOk) || state == DISCARD);
   end

   always_ff @(posedge clk)
      if (state == PAYLOAD && sHs && !lenFull) mem[IW'(len)] <= bus.s_axis_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         len              <= '0;
         rdPtr            <= '0;
         emitLen          <= '0;
         tsCount          <= '0;
         bus.m_axis_valid <= 1'b0;
         bus.m_axis_data  <= 8'h00;
         bus.m_axis_last  <= 1'b0;
         bus.m_sev        <= 2'd0;
         bus.m_verb       <= 2'd0;
         bus.m_trunc      <= 1'b0;
         bus.m_empty      <= 1'b0;
         bus.m_timestamp  <= '0;
      end else begin
         tsCount <= tsCount + TS_WIDTH'(1);
         case (state)
            IDLE: if (sHs) begin
               bus.m_sev       <= bus.s_axis_data[3:2];
               bus.m_verb      <= bus.s_axis_data[1:0];
               bus.m_timestamp <= tsCount;
               bus.m_trunc     <= 1'b0;
               bus.m_empty     <= 1'b0;
               len             <= '0;
               rdPtr           <= '0;
               if (!hdrOk) state <= bus.s_axis_last ? IDLE : DISCARD;
               else if (bus.s_axis_last) begin
                  state            <= EMIT;
                  bus.m_empty      <= 1'b1;
                  bus.m_axis_valid <= 1'b1;
                  bus.m_axis_data  <= 8'h00;
                  bus.m_axis_last  <= 1'b1;
                  emitLen          <= LW'(1);
               end else state <= PAYLOAD;
            end
            PAYLOAD: if (sHs) begin
               len <= nextLen;
               if (lenFull) bus.m_trunc <= 1'b1;
               if (bus.s_axis_last) begin
                  // the final byte may land in mem[0] on this same edge, so bypass it
                  state            <= EMIT;
                  bus.m_axis_valid <= 1'b1;
                  bus.m_axis_data  <= len == '0 ? bus.s_axis_data : mem[0];
                  bus.m_axis_last  <= nextLen == LW'(1);
                  emitLen          <= nextLen;
               end
            end
            DISCARD: if (sHs && bus.s_axis_last) state <= IDLE;
            default: if (mHs) begin
               if (bus.m_axis_last) begin
                  state            <= IDLE;
                  bus.m_axis_valid <= 1'b0;
                  bus.m_axis_last  <= 1'b0;
               end else begin
                  rdPtr           <= rdPtr + LW'(1);
                  bus.m_axis_data <= mem[IW'(rdPtr + LW'(1))];
                  bus.m_axis_last <= (rdPtr + LW'(2)) == emitLen;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_info    <= '0;
         cnt_warning <= '0;
         cnt_error   <= '0;
         cnt_dropped <= '0;
         fatal_seen  <= 1'b0;
      end else begin
         cnt_info    <= satInc(cnt_info, commitFwd && fwdSev == 2'd0);
         cnt_warning <= satInc(cnt_warning, commitFwd && fwdSev == 2'd1);
         cnt_error   <= satInc(cnt_error, commitFwd && fwdSev[1]);
         cnt_dropped <= satInc(cnt_dropped, commitDrop);
         fatal_seen  <= fatal_seen || (commitFwd && fwdSev == 2'd3);
      end
   end
endmodule

// File: tb/tb_log_msg_receiver.sv
// tb_log_msg_receiver: randomized scoreboard bench; a message-level reference model
// queues expected output beats and a negedge monitor compares them as they appear
module tb_log_msg_receiver;
   localparam int MAX_LEN   = 128;
   localparam int TS_WIDTH  = 32;
   localparam int CNT_WIDTH = 4;
   localparam int CMAX      = (1 << CNT_WIDTH) - 1;
   localparam int LIMIT     = 3000;

   typedef struct {
      logic [7:0]          data;
      logic                last;
      logic [1:0]          sev;
      logic [1:0]          verb;
      logic                trunc;
      logic                empty;
      logic [TS_WIDTH-1:0] ts;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [1:0]           cfgVerb = 2'd0;
   logic [CNT_WIDTH-1:0] cntInfo, cntWarning, cntError, cntDropped;
   logic                 fatalSeen;
   logic [TS_WIDTH-1:0]  cyc;
   logic [7:0]           payload[$];
   beat_t                expQ[$];
   int                   checks = 0, errors = 0, beatsSeen = 0, readyMode = 0;
   int                   expInfo = 0, expWarning = 0, expError = 0, expDropped = 0;
   bit                   expFatal = 0;

   log_msg_if #(.TS_WIDTH(TS_WIDTH)) bus ();

   log_msg_receiver #(.MAX_LEN(MAX_LEN), .TS_WIDTH(TS_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst(rst), .cfg_verbosity(cfgVerb), .bus(bus.slave),
      .cnt_info(cntInfo), .cnt_warning(cntWarning), .cnt_error(cntError),
      .cnt_dropped(cntDropped), .fatal_seen(fatalSeen)
   );

   always #5 clk = ~clk;

   // cycle count since reset: the timestamp a header accepted on the next edge must carry
   always @(posedge clk) cyc <= rst ? '0 : cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   function automatic int satInc(input int c);
      return c < CMAX ? c + 1 : c;
   endfunction

   task automatic checkCounters();
      check("cnt_info", 64'(cntInfo), 64'(expInfo));
      check("cnt_warning", 64'(cntWarning), 64'(expWarning));
      check("cnt_error", 64'(cntError), 64'(expError));
      check("cnt_dropped", 64'(cntDropped), 64'(expDropped));
      check("fatal_seen", 64'(fatalSeen), 64'(expFatal));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic l, output logic [TS_WIDTH-1:0] ts, output int waited);
      bus.s_axis_valid = 1'b1;
      bus.s_axis_data  = b;
      bus.s_axis_last  = l;
      waited = 0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge clk);
         if (bus.s_axis_ready) break;
         waited++;
      end
      if (waited >= LIMIT) check("s_ready_timeout", 64'(waited), 64'(0));
      ts = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic sendMsg(input logic [7:0] hdr);
      logic [TS_WIDTH-1:0] ts, tsDummy;
      int    waited, n, k;
      bit    fwd;
      beat_t e;
      n   = payload.size();
      k   = n > MAX_LEN ? MAX_LEN : n;
      fwd = hdr[7:4] == 4'hA && !(hdr[3:2] == 2'd0 && hdr[1:0] > cfgVerb);
      sendByte(hdr, n == 0, ts, waited);
      if (fwd) begin
         e.sev = hdr[3:2]; e.verb = hdr[1:0]; e.ts = ts;
         e.trunc = n > MAX_LEN; e.empty = n == 0;
         if (n == 0) begin
            e.data = 8'h00; e.last = 1'b1;
            expQ.push_back(e);
         end else
            for (int i = 0; i < k; i++) begin
               e.data = payload[i]; e.last = i == k - 1;
               expQ.push_back(e);
            end
      end
      for (int i = 0; i < n; i++) begin
         sendByte(payload[i], i == n - 1, tsDummy, waited);
         check("s_ready_during_message", 64'(waited), 64'(0));
      end
      bus.s_axis_valid = 1'b0;
      bus.s_axis_last  = 1'b0;
      if (!fwd) expDropped = satInc(expDropped);
      else if (hdr[3:2] == 2'd0) expInfo = satInc(expInfo);
      else if (hdr[3:2] == 2'd1) expWarning = satInc(expWarning);
      else expError = satInc(expError);
      if (fwd && hdr[3:2] == 2'd3) expFatal = 1;
      checkCounters();
   endtask

   initial begin
      bus.m_axis_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.m_axis_ready = readyMode == 0 ? 1'b1 : readyMode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      beat_t e;
      bit    expectReady = 0;
      forever begin
         @(negedge clk);
         if (rst) expectReady = 0;
         else begin
            if (expectReady) begin
               check("s_ready_after_emit", 64'(bus.s_axis_ready), 64'(1));
               expectReady = 0;
            end
            if (bus.m_axis_valid) begin
               check("s_ready_stalled_in_emit", 64'(bus.s_axis_ready), 64'(0));
               if (bus.m_axis_ready) begin
                  if (expQ.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_beat: got data %0h, expected no output", bus.m_axis_data);
                  end else begin
                     e = expQ.pop_front();
                     check("m_axis_data", 64'(bus.m_axis_data), 64'(e.data));
                     check("m_axis_last", 64'(bus.m_axis_last), 64'(e.last));
                     check("m_sev", 64'(bus.m_sev), 64'(e.sev));
                     check("m_verb", 64'(bus.m_verb), 64'(e.verb));
                     check("m_trunc", 64'(bus.m_trunc), 64'(e.trunc));
                     check("m_empty", 64'(bus.m_empty), 64'(e.empty));
                     check("m_timestamp", 64'(bus.m_timestamp), 64'(e.ts));
                  end
                  beatsSeen++;
                  if (bus.m_axis_last) expectReady = 1;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      bus.s_axis_valid = 1'b0;
      bus.s_axis_data  = 8'h00;
      bus.s_axis_last  = 1'b0;
      idle(3);
      check("rst_m_axis_valid", 64'(bus.m_axis_valid), 64'(0));
      check("rst_m_axis_data", 64'(bus.m_axis_data), 64'(0));
      check("rst_m_axis_last", 64'(bus.m_axis_last), 64'(0));
      check("rst_s_axis_ready", 64'(bus.s_axis_ready), 64'(1));
      check("rst_meta", 64'({bus.m_sev, bus.m_verb, bus.m_trunc, bus.m_empty}), 64'(0));
      check("rst_m_timestamp", 64'(bus.m_timestamp), 64'(0));
      checkCounters();
      rst = 1'b0;
      idle(2);

      cfgVerb = 2'd3;
      payload = '{8'h4F, 8'h4B};
      sendMsg(8'hA1);
      idle(4);

      cfgVerb = 2'd1;
      payload = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      sendMsg(8'hA3);
      payload = '{8'h5A};
      sendMsg(8'hA8);
      idle(4);

      payload = '{8'h01, 8'h02, 8'h03};
      sendMsg(8'h51);
      payload.delete();
      sendMsg(8'hAC);
      idle(4);

      payload.delete();
      for (int i = 0; i < 130; i++) payload.push_back(8'(i));
      sendMsg(8'hA4);
      payload.delete();
      for (int i = 0; i < 128; i++) payload.push_back(8'(255 - i));
      sendMsg(8'hA9);

      readyMode = 1;
      for (int m = 0; m < 40; m++) begin
         cfgVerb = 2'($urandom_range(0, 3));
         n = $urandom_range(0, 3) == 0 ? $urandom_range(125, 131) : $urandom_range(0, 8);
         payload.delete();
         for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
         sendMsg($urandom_range(0, 4) == 0 ? 8'($urandom) : {4'hA, 4'($urandom)});
         idle($urandom_range(0, 2));
      end

      readyMode = 0;
      payload.delete();
      for (int i = 0; i < 10; i++) payload.push_back(8'(8'hC0 + i));
      sendMsg(8'hA4);
      base = beatsSeen;
      for (int i = 0; i < LIMIT && beatsSeen < base + 3; i++) idle(1);
      check("three_beats_before_reset", 64'(beatsSeen - base), 64'(3));
      readyMode = 2;
      rst = 1'b1;
      idle(1);
      check("reset_m_axis_valid", 64'(bus.m_axis_valid), 64'(0));
      check("reset_m_axis_data", 64'(bus.m_axis_data), 64'(0));
      check("reset_s_axis_ready", 64'(bus.s_axis_ready), 64'(1));
      expQ.delete();
      expInfo = 0; expWarning = 0; expError = 0; expDropped = 0; expFatal = 0;
      checkCounters();
      rst = 1'b0;
      readyMode = 0;
      idle(1);
      cfgVerb = 2'd2;
      payload = '{8'h68, 8'h69, 8'h21};
      sendMsg(8'hA6);

      for (int i = 0; i < LIMIT && expQ.size() != 0; i++) idle(1);
      idle(2);
      check("queue_drained", 64'(expQ.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
